// File: rtl/texture_stream_arbiter_if.sv
// Texture upload stream bundle shared by the two upload sources and the
// texture buffer write port. The arbiter takes the sources as slaves and
// drives the buffer side as a master.
interface texture_stream_arbiter_if #(
  parameter int STREAM_WIDTH = 32
);
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic [STREAM_WIDTH-1:0] tdata;

  modport master (
    output tvalid,
    output tlast,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tlast,
    input  tdata,
    output tready
  );
endinterface

// File: rtl/texture_stream_arbiter.sv
// Texture stream arbiter: shares the texture buffer write stream between the
// command-parser upload (source 0) and the second texture unit loader
// (source 1). Grants are round-robin per packet and held until tlast. The
// output passes through a single register stage. New grants are held off
// while the renderer asks for quiescence. Each packet's beat count is
// compared with the expected length latched at grant time, and a sticky flag
// is raised on a mismatch.
module texture_stream_arbiter #(
  parameter int STREAM_WIDTH = 32,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  quiesce,
  output logic                  busy,
  output logic                  grant,
  input  logic [LEN_WIDTH-1:0]  expectedBeats0,
  input  logic [LEN_WIDTH-1:0]  expectedBeats1,
  output logic                  lengthError,
  input  logic                  clearError,
  texture_stream_arbiter_if.slave  s0_axis,
  texture_stream_arbiter_if.slave  s1_axis,
  texture_stream_arbiter_if.master m_axis
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic                    r_grant;
  logic                    r_lastGrant;
  logic [LEN_WIDTH-1:0]    r_count;
  logic [LEN_WIDTH-1:0]    r_expected;
  logic                    r_mValid;
  logic                    r_mLast;
  logic [STREAM_WIDTH-1:0] r_mData;
  logic                    r_lengthError;

  logic                    w_grantNow;
  logic                    w_winner;
  logic                    w_inValid;
  logic                    w_inLast;
  logic [STREAM_WIDTH-1:0] w_inData;
  logic                    w_srcReady;
  logic                    w_accept;
  logic                    w_endOfPacket;
  logic [LEN_WIDTH-1:0]    w_countNext;
  logic                    w_lenMismatch;

  // The granted source may push whenever the output register is empty or
  // draining this cycle; tready never depends on the source's own tvalid.
  assign w_srcReady     = (r_state == STREAM) && (!r_mValid || m_axis.tready);
  assign s0_axis.tready = w_srcReady && !r_grant;
  assign s1_axis.tready = w_srcReady &&  r_grant;

  assign w_accept      = w_srcReady && w_inValid;
  assign w_endOfPacket = w_accept && w_inLast;
  assign w_countNext   = r_count + LEN_WIDTH'(1);
  assign w_lenMismatch = w_endOfPacket && (r_expected != '0) && (w_countNext != r_expected);

  assign m_axis.tvalid = r_mValid;
  assign m_axis.tlast  = r_mLast;
  assign m_axis.tdata  = r_mData;

  assign busy        = (r_state == STREAM) || r_mValid;
  assign grant       = r_grant;
  assign lengthError = r_lengthError;

  // Steer the granted source's beat toward the output register.
  always_comb begin
    w_inValid = s0_axis.tvalid;
    w_inLast  = s0_axis.tlast;
    w_inData  = s0_axis.tdata;
    if (r_grant) begin
      w_inValid = s1_axis.tvalid;
      w_inLast  = s1_axis.tlast;
      w_inData  = s1_axis.tdata;
    end
  end

  // Next-state and arbitration: a grant starts only from IDLE with quiesce low,
  // and a packet ends on an accepted tlast beat.
  always_comb begin
    w_nextState = r_state;
    w_grantNow  = 1'b0;
    w_winner    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!quiesce && (s0_axis.tvalid || s1_axis.tvalid)) begin
          w_grantNow  = 1'b1;
          w_nextState = STREAM;
          if (s0_axis.tvalid && s1_axis.tvalid) begin
            w_winner = !r_lastGrant;
          end else begin
            w_winner = s1_axis.tvalid;
          end
        end
      end
      STREAM: begin
        if (w_endOfPacket) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Grant bookkeeping: latch the winner and its expected length at grant time,
  // count accepted beats, and remember who finished last for round-robin.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_grant     <= 1'b0;
      r_lastGrant <= 1'b1;
      r_count     <= '0;
      r_expected  <= '0;
    end else begin
      if (w_grantNow) begin
        r_grant    <= w_winner;
        r_count    <= '0;
        r_expected <= w_winner ? expectedBeats1 : expectedBeats0;
      end else if (w_accept) begin
        r_count <= w_countNext;
      end
      if (w_endOfPacket) begin
        r_lastGrant <= r_grant;
      end
    end
  end

  // Output pipeline register: load on an accepted beat, empty once the
  // buffer has taken the held beat and nothing new arrives.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_mValid <= 1'b0;
      r_mLast  <= 1'b0;
      r_mData  <= '0;
    end else if (w_accept) begin
      r_mValid <= 1'b1;
      r_mLast  <= w_inLast;
      r_mData  <= w_inData;
    end else if (m_axis.tready) begin
      r_mValid <= 1'b0;
    end
  end

  // Sticky length-mismatch flag; a fresh mismatch beats a simultaneous clear.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_lengthError <= 1'b0;
    end else if (w_lenMismatch) begin
      r_lengthError <= 1'b1;
    end else if (clearError) begin
      r_lengthError <= 1'b0;
    end
  end

endmodule

// File: tb/tb_texture_stream_arbiter.sv
// Self-checking bench for texture_stream_arbiter. Sources are fed from beat
// queues; the expected output order comes from a packet-level round-robin
// model, and per-cycle checks cover latency, backpressure and grant ownership.
module tb_texture_stream_arbiter;
  localparam int SW = 32;
  localparam int LW = 16;

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic          quiesce = 1'b0;
  logic          clearError = 1'b0;
  logic [LW-1:0] expectedBeats0 = '0;
  logic [LW-1:0] expectedBeats1 = '0;
  logic          busy;
  logic          grant;
  logic          lengthError;

  texture_stream_arbiter_if #(.STREAM_WIDTH(SW)) s0If ();
  texture_stream_arbiter_if #(.STREAM_WIDTH(SW)) s1If ();
  texture_stream_arbiter_if #(.STREAM_WIDTH(SW)) mIf ();

  texture_stream_arbiter #(.STREAM_WIDTH(SW), .LEN_WIDTH(LW)) dut (
    .aclk           (aclk),
    .reset          (reset),
    .quiesce        (quiesce),
    .busy           (busy),
    .grant          (grant),
    .expectedBeats0 (expectedBeats0),
    .expectedBeats1 (expectedBeats1),
    .lengthError    (lengthError),
    .clearError     (clearError),
    .s0_axis        (s0If),
    .s1_axis        (s1If),
    .m_axis         (mIf)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [SW-1:0] data;
    logic          last;
  } beat_t;

  beat_t src0Q[$];
  beat_t src1Q[$];
  beat_t mdl0Q[$];
  beat_t mdl1Q[$];
  beat_t expQ[$];
  beat_t gotQ[$];

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            readyMode = 0;
  int            acc0 = 0;
  int            acc1 = 0;
  bit            pendLat = 1'b0;
  beat_t         pendBeat;
  bit            noReady0 = 1'b0;
  bit            modelLastGrant = 1'b1;
  logic          nReset = 1'b1;
  logic          nQuiesce = 1'b0;
  logic          nClear = 1'b0;
  logic [LW-1:0] nExp0 = '0;
  logic [LW-1:0] nExp1 = '0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample before the next posedge.
  task automatic applyStimulus();
    bit f0, f1, fm;
    @(negedge aclk);
    reset          = nReset;
    quiesce        = nQuiesce;
    clearError     = nClear;
    expectedBeats0 = nExp0;
    expectedBeats1 = nExp1;
    if (src0Q.size() > 0) begin
      s0If.tvalid = 1'b1; s0If.tdata = src0Q[0].data; s0If.tlast = src0Q[0].last;
    end else begin
      s0If.tvalid = 1'b0; s0If.tdata = '0; s0If.tlast = 1'b0;
    end
    if (src1Q.size() > 0) begin
      s1If.tvalid = 1'b1; s1If.tdata = src1Q[0].data; s1If.tlast = src1Q[0].last;
    end else begin
      s1If.tvalid = 1'b0; s1If.tdata = '0; s1If.tlast = 1'b0;
    end
    case (readyMode)
      0:       mIf.tready = 1'b1;
      1:       mIf.tready = 1'($urandom_range(0, 1));
      default: mIf.tready = ((cyc % 3) == 0);
    endcase
    #1;
    f0 = s0If.tvalid && s0If.tready && !reset;
    f1 = s1If.tvalid && s1If.tready && !reset;
    fm = mIf.tvalid && mIf.tready;
    if (pendLat) begin
      checkOutput("latency_valid", 64'(mIf.tvalid), 64'd1);
      checkOutput("latency_beat", 64'({mIf.tdata, mIf.tlast}), 64'(pendBeat));
    end
    if (mIf.tvalid && !mIf.tready) begin
      checkOutput("bp_ready0", 64'(s0If.tready), 64'd0);
      checkOutput("bp_ready1", 64'(s1If.tready), 64'd0);
    end
    if (s0If.tready) checkOutput("exclusive_ready", 64'(s1If.tready), 64'd0);
    if (f0) checkOutput("grant_s0", 64'(grant), 64'd0);
    if (f1) checkOutput("grant_s1", 64'(grant), 64'd1);
    if (noReady0) checkOutput("quiesce_ready0", 64'(s0If.tready), 64'd0);
    if (fm) gotQ.push_back({mIf.tdata, mIf.tlast});
    pendLat = f0 || f1;
    if (f0) begin pendBeat = src0Q.pop_front(); acc0++; end
    else if (f1) begin pendBeat = src1Q.pop_front(); acc1++; end
    cyc++;
  endtask

  // Queue a packet on a source; either straight into the expected stream or
  // into the per-source model queues for round-robin ordering.
  task automatic addPacket(input int src, input int len, input bit toExp, input bit fixed, input int base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = fixed ? SW'(base + i) : {src[0], 31'($urandom())};
      b.last = (i == len - 1);
      if (src == 0) src0Q.push_back(b); else src1Q.push_back(b);
      if (toExp) expQ.push_back(b);
      else if (src == 0) mdl0Q.push_back(b);
      else mdl1Q.push_back(b);
    end
  endtask

  // Packet-level round-robin: alternate while both have packets, favouring
  // the source that did not finish last.
  task automatic buildExpected();
    bit pick;
    beat_t b;
    while (mdl0Q.size() > 0 || mdl1Q.size() > 0) begin
      if (mdl0Q.size() > 0 && mdl1Q.size() > 0) pick = !modelLastGrant;
      else pick = (mdl1Q.size() > 0);
      do begin
        b = pick ? mdl1Q.pop_front() : mdl0Q.pop_front();
        expQ.push_back(b);
      end while (!b.last);
      modelLastGrant = pick;
    end
  endtask

  task automatic drainAndCompare(input string tag, input int budget);
    int n = 0;
    bit timedOut;
    while (!(src0Q.size() == 0 && src1Q.size() == 0 && gotQ.size() == expQ.size() && busy === 1'b0)
           && n < budget) begin
      applyStimulus();
      n++;
    end
    timedOut = (n >= budget);
    checkOutput({tag, "_timeout"}, 64'(timedOut), 64'd0);
    checkOutput({tag, "_count"}, 64'(gotQ.size()), 64'(expQ.size()));
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
      checkOutput($sformatf("%s_beat%0d", tag, i), 64'(gotQ[i]), 64'(expQ[i]));
    gotQ.delete();
    expQ.delete();
  endtask

  task automatic resetDut();
    src0Q.delete(); src1Q.delete(); mdl0Q.delete(); mdl1Q.delete();
    nReset = 1'b1;
    applyStimulus();
    nReset = 1'b0;
    gotQ.delete(); expQ.delete();
    pendLat = 1'b0;
    modelLastGrant = 1'b1;
  endtask

  initial begin
    int n;
    bit expErr;
    int len;
    s0If.tvalid = 1'b0; s0If.tdata = '0; s0If.tlast = 1'b0;
    s1If.tvalid = 1'b0; s1If.tdata = '0; s1If.tlast = 1'b0;
    mIf.tready = 1'b1;

    // Reset values
    applyStimulus();
    resetDut();
    applyStimulus();
    checkOutput("rst_mvalid", 64'(mIf.tvalid), 64'd0);
    checkOutput("rst_mlast", 64'(mIf.tlast), 64'd0);
    checkOutput("rst_mdata", 64'(mIf.tdata), 64'd0);
    checkOutput("rst_ready0", 64'(s0If.tready), 64'd0);
    checkOutput("rst_ready1", 64'(s1If.tready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_grant", 64'(grant), 64'd0);
    checkOutput("rst_lenerr", 64'(lengthError), 64'd0);

    // Single 4-beat packet, expected length matches
    nExp0 = 16'd4;
    addPacket(0, 4, 1'b1, 1'b1, 'hA0);
    n = 0;
    while (gotQ.size() < 4 && n < 30) begin applyStimulus(); n++; end
    applyStimulus();
    checkOutput("single_busy_drop", 64'(busy), 64'd0);
    checkOutput("single_mvalid_drop", 64'(mIf.tvalid), 64'd0);
    drainAndCompare("single", 20);
    checkOutput("single_lenerr", 64'(lengthError), 64'd0);

    // Round-robin with both sources continuously valid
    resetDut();
    for (int p = 0; p < 4; p++) begin
      addPacket(0, 2, 1'b0, 1'b0, 0);
      addPacket(1, 2, 1'b0, 1'b0, 0);
    end
    buildExpected();
    drainAndCompare("rr", 100);
    checkOutput("rr_final_grant", 64'(grant), 64'd1);

    // Backpressure pattern 1,0,0 on an 8-beat packet
    resetDut();
    readyMode = 2;
    addPacket(0, 8, 1'b1, 1'b0, 0);
    drainAndCompare("bp", 100);
    readyMode = 0;

    // Quiesce raised mid-packet on source 1 with source 0 pending
    resetDut();
    nExp0 = '0;
    addPacket(1, 4, 1'b1, 1'b0, 0);
    acc1 = 0;
    n = 0;
    while (acc1 < 2 && n < 20) begin applyStimulus(); n++; end
    nQuiesce = 1'b1;
    addPacket(0, 2, 1'b1, 1'b0, 0);
    noReady0 = 1'b1;
    n = 0;
    while (!(src1Q.size() == 0 && busy === 1'b0) && n < 30) begin applyStimulus(); n++; end
    checkOutput("quiesce_s1_done", 64'(src1Q.size()), 64'd0);
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("quiesce_idle_busy", 64'(busy), 64'd0);
    nQuiesce = 1'b0;
    applyStimulus();
    noReady0 = 1'b0;
    applyStimulus();
    checkOutput("quiesce_grant_ready0", 64'(s0If.tready), 64'd1);
    drainAndCompare("quiesce", 30);

    // Length check: short packet, sticky flag, clear
    resetDut();
    nExp0 = 16'd4;
    addPacket(0, 3, 1'b1, 1'b0, 0);
    drainAndCompare("len_short", 30);
    checkOutput("len_err_set", 64'(lengthError), 64'd1);
    applyStimulus();
    applyStimulus();
    checkOutput("len_err_sticky", 64'(lengthError), 64'd1);
    nClear = 1'b1;
    applyStimulus();
    nClear = 1'b0;
    applyStimulus();
    checkOutput("len_err_cleared", 64'(lengthError), 64'd0);
    nExp0 = '0;
    addPacket(0, 5, 1'b1, 1'b0, 0);
    drainAndCompare("len_nocheck", 30);
    checkOutput("len_nocheck_flag", 64'(lengthError), 64'd0);

    // Reset in the middle of a 5-beat packet
    resetDut();
    addPacket(0, 5, 1'b1, 1'b0, 0);
    acc0 = 0;
    n = 0;
    while (acc0 < 2 && n < 20) begin applyStimulus(); n++; end
    nReset = 1'b1;
    applyStimulus();
    nReset = 1'b0;
    src0Q.delete(); gotQ.delete(); expQ.delete();
    pendLat = 1'b0;
    applyStimulus();
    checkOutput("midrst_mvalid", 64'(mIf.tvalid), 64'd0);
    checkOutput("midrst_ready0", 64'(s0If.tready), 64'd0);
    checkOutput("midrst_ready1", 64'(s1If.tready), 64'd0);
    checkOutput("midrst_grant", 64'(grant), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    addPacket(1, 3, 1'b1, 1'b0, 0);
    drainAndCompare("midrst_s1", 30);
    checkOutput("midrst_s1_grant", 64'(grant), 64'd1);

    // Randomized packets and backpressure against the round-robin model
    resetDut();
    nExp0 = 16'd3;
    nExp1 = '0;
    readyMode = 1;
    expErr = 1'b0;
    for (int p = 0; p < 6; p++) begin
      len = $urandom_range(1, 5);
      if (len != 3) expErr = 1'b1;
      addPacket(0, len, 1'b0, 1'b0, 0);
      len = $urandom_range(1, 5);
      addPacket(1, len, 1'b0, 1'b0, 0);
    end
    buildExpected();
    drainAndCompare("rand", 800);
    checkOutput("rand_lenerr", 64'(lengthError), 64'(expErr));
    readyMode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/texture_stream_arbiter.md
Name: texture_stream_arbiter

Overview:
- Shares the single texture-write AXI stream of the texture buffer between two upload sources: the command-parser texture upload and the second texture unit loader.
- Arbitrates round-robin at packet granularity, locks a grant until tlast, and registers the output stream.
- Holds off new grants while the renderer requests quiescence, so a texture is never replaced while the sampler is reading it.
- Checks each packet's beat count against an expected length and flags mismatches.

Parameters:
- STREAM_WIDTH, 32, data width of all stream ports.
- LEN_WIDTH, 16, width of the expected-beat-count inputs and the internal beat counter.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- quiesce  in  1  1 = no new grant may start; an active packet is unaffected.
- busy  out  1  1 while a packet is granted or the output register holds data.
- grant  out  1  index of the current or last granted source.
- expectedBeats0  in  LEN_WIDTH  expected beats per packet on source 0; 0 = no check.
- expectedBeats1  in  LEN_WIDTH  same, for source 1.
- lengthError  out  1  sticky beat-count mismatch flag.
- clearError  in  1  clears lengthError.
- s0_axis_tvalid / s0_axis_tready / s0_axis_tlast / s0_axis_tdata  in/out/in/in  1/1/1/STREAM_WIDTH  source 0 stream.
- s1_axis_tvalid / s1_axis_tready / s1_axis_tlast / s1_axis_tdata  in/out/in/in  1/1/1/STREAM_WIDTH  source 1 stream.
- m_axis_tvalid / m_axis_tready / m_axis_tlast / m_axis_tdata  out/in/out/out  1/1/1/STREAM_WIDTH  stream to the texture buffer write port.

Behaviour:
- Reset values:
  - state IDLE; all s*_tready = 0; m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0.
  - busy = 0, grant = 0, lengthError = 0, beat counter = 0.
  - lastGrant = 1, so source 0 wins the first arbitration.
- Reset mid-packet: the output register is discarded and the packet is not completed downstream; the sources must restart.

State IDLE:
- All s*_tready = 0.
- If quiesce = 0 and any s*_tvalid = 1: grant the requesting source.
- If both request, grant the source != lastGrant.
- On a grant: grant <= winner, counter <= 0, go to STREAM.
- Arbitration takes one cycle, so there is at least one idle input cycle between packets.

State STREAM:
- Only the granted source sees tready.
- s_tready(granted) = !m_axis_tvalid || m_axis_tready (single pipeline register, no combinational path from tvalid to tready).
- On an accepted input beat:
  - the output register loads tdata and tlast, and m_axis_tvalid <= 1;
  - counter <= counter + 1, wrapping at 2^LEN_WIDTH.
- On an accepted beat with tlast = 1:
  - if expected != 0 and counter + 1 != expected, set lengthError;
  - lastGrant <= grant; go to IDLE.
- The output register clears m_axis_tvalid when m_axis_tready = 1 and no new beat loads.
- Latency is exactly 1 cycle from input acceptance to m_axis_tvalid.
- Throughput is 1 beat per cycle while m_axis_tready = 1.
- Data and tlast are never modified; a length mismatch only sets the flag.
- quiesce asserted during STREAM has no effect until tlast is accepted; the next grant then waits until quiesce = 0.
- expectedBeats* is sampled at grant time; changes mid-packet are ignored.

Other outputs:
- busy = (state == STREAM) || m_axis_tvalid.
- lengthError: if clearError and a new error occur in the same cycle, the error wins (flag = 1).
- A non-granted source asserting tvalid mid-packet sees tready = 0 until it is granted.

Test Plan:
- Single packet: s0 sends 4 beats (0xA0..0xA3, tlast on the 4th), expectedBeats0 = 4, m_tready = 1 → m_axis carries the same 4 beats 1 cycle later with tlast on 0xA3; lengthError = 0; busy drops the cycle after the last output beat.
- Round-robin: both sources continuously valid with 2-beat packets → output packet order s0, s1, s0, s1; grant toggles; there are no interleaved beats within a packet.
- Backpressure: 8-beat packet with m_tready toggling 1,0,0,1,… → no beat is lost or duplicated; s0_tready = 0 whenever the output register is full and m_tready = 0; the beat sequence equals the input sequence.
- Quiesce: quiesce = 1 raised after beat 2 of a 4-beat s1 packet → the packet completes; a pending s0 packet gets no tready until quiesce = 0, then is granted 1 cycle later.
- Length check: expectedBeats0 = 4, packet with tlast on beat 3 → lengthError = 1 after tlast and stays 1; clearError pulse → 0. With expectedBeats0 = 0 and any length → flag stays 0.
- Reset mid-packet: reset = 1 for one cycle during beat 2 of 5 → next cycle m_axis_tvalid = 0, all tready = 0, grant = 0, busy = 0; a fresh s1-only request is then granted normally.
